// File: rtl/led_pwm.sv
// Multi-channel LED PWM with shadowed duty registers committed at frame boundaries.
// Define LED_PWM_FADE_EN to step each active duty one count toward its target per frame.
module led_pwm #(
    parameter int NUM_LEDS = 11,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 125
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [PWM_BITS-1:0] wr_data,
    output logic                wr_ready,
    output logic                frame_start,
    output logic [NUM_LEDS-1:0] ledc
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_frame_start;
    logic [NUM_LEDS-1:0] r_ledc;
    logic [PWM_BITS-1:0] r_shadow [NUM_LEDS];
    logic [PWM_BITS-1:0] r_active [NUM_LEDS];

    logic                w_step;
    logic                w_wrap;
    logic                w_wr_acc;
    logic [PWM_BITS-1:0] w_act_nxt [NUM_LEDS];
    logic [PWM_BITS-1:0] w_duty    [NUM_LEDS];
    logic [NUM_LEDS-1:0] w_ledc_nxt;

    assign w_step      = (r_presc == PS_LAST);
    assign w_wrap      = w_step && (r_pwm == PWM_LAST);
    assign wr_ready    = ~r_frame_start;
    assign w_wr_acc    = wr_en && wr_ready;
    assign frame_start = r_frame_start;
    assign ledc        = r_ledc;

    // During the commit cycle the compare already uses the incoming duty,
    // so the first step of the new frame is never drawn with the old value.
    always_comb begin
        w_ledc_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef LED_PWM_FADE_EN
            if (r_active[i] < r_shadow[i]) begin
                w_act_nxt[i] = r_active[i] + 1'b1;
            end else if (r_active[i] > r_shadow[i]) begin
                w_act_nxt[i] = r_active[i] - 1'b1;
            end else begin
                w_act_nxt[i] = r_active[i];
            end
`else
            w_act_nxt[i] = r_shadow[i];
`endif
            w_duty[i]     = r_frame_start ? w_act_nxt[i] : r_active[i];
            w_ledc_nxt[i] = (r_pwm < w_duty[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_pwm         <= '0;
            r_frame_start <= 1'b0;
            r_ledc        <= '0;
        end else begin
            r_presc <= w_step ? '0 : r_presc + 1'b1;
            if (w_step) begin
                r_pwm <= (r_pwm == PWM_LAST) ? '0 : r_pwm + 1'b1;
            end
            r_frame_start <= w_wrap;
            r_ledc        <= w_ledc_nxt;
        end
    end

    // Out-of-range addresses match no channel and are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_wr_acc && (wr_addr == 4'(i))) begin
                    r_shadow[i] <= wr_data;
                end
                if (r_frame_start) begin
                    r_active[i] <= w_act_nxt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm.sv
// Bench for led_pwm: frame-level reference model checked every cycle plus
// hand-computed duty/period expectations.
module tb_led_pwm;

    localparam int NL = 11;
    localparam int PB = 8;
    localparam int PS = 2;
    localparam int FR = PS * ((1 << PB) - 1);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [PB-1:0] wr_data;
    logic          wr_ready;
    logic          frame_start;
    logic [NL-1:0] ledc;

    int n_chk;
    int n_err;
    bit cmp_en;
    int hi_cnt [NL];

    led_pwm #(
        .NUM_LEDS (NL),
        .PWM_BITS (PB),
        .PRESCALE (PS)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_start (frame_start),
        .ledc        (ledc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since reset release; a frame is FR
    // cycles and the commit cycle is every nonzero multiple of FR.
    int            m_t;
    logic [PB-1:0] m_sh  [NL];
    logic [PB-1:0] m_act [NL];
    logic [NL-1:0] m_ledc;

    function automatic bit m_commit(input int t);
        return (t > 0) && (t % FR == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0;
            m_ledc = '0;
            for (int i = 0; i < NL; i++) begin
                m_sh[i] = '0;
                m_act[i] = '0;
            end
        end else begin
            if (m_commit(m_t)) begin
                for (int i = 0; i < NL; i++) begin
`ifdef LED_PWM_FADE_EN
                    if (m_act[i] < m_sh[i]) m_act[i] = m_act[i] + 1;
                    else if (m_act[i] > m_sh[i]) m_act[i] = m_act[i] - 1;
`else
                    m_act[i] = m_sh[i];
`endif
                end
            end
            if (wr_en && !m_commit(m_t) && int'(wr_addr) < NL)
                m_sh[wr_addr] = wr_data;
            for (int i = 0; i < NL; i++)
                m_ledc[i] = ((m_t % FR) / PS) < int'(m_act[i]);
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ledc", 32'(ledc), 32'(m_ledc));
            chk("frame_start", 32'(frame_start), 32'(m_commit(m_t)));
            chk("wr_ready", 32'(wr_ready), 32'(!m_commit(m_t)));
        end
    end

    task automatic wait_commit();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < FR + 10);
        chk("commit_seen", 32'(frame_start), 1);
    endtask

    // Counts lit cycles per channel over one frame, starting at a commit negedge.
    task automatic measure();
        for (int i = 0; i < NL; i++) hi_cnt[i] = 0;
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++)
                if (ledc[i]) hi_cnt[i]++;
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [PB-1:0] d);
        bit ok;
        ok = 1'b0;
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            ok = wr_ready;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        chk("write_handshake", 32'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int last;
        int pulses;
        int bad_gap;
        int nz;
        n_chk = 0;
        n_err = 0;
        cmp_en = 1'b0;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_ledc", 32'(ledc), 0);
        chk("reset_ready", 32'(wr_ready), 1);
        chk("reset_fs", 32'(frame_start), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle: frame period and dark outputs
        first = 0; last = 0; pulses = 0; bad_gap = 0; nz = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (ledc != '0) nz++;
            if (frame_start) begin
                if (pulses == 0) first = k;
                else if (k - last != FR) bad_gap++;
                last = k;
                pulses++;
            end
        end
        chk("idle_first_fs", 32'(first), 511);
        chk("idle_pulses", 32'(pulses), 3);
        chk("idle_gap", 32'(bad_gap), 0);
        chk("idle_dark", 32'(nz), 0);

        // Full-on and half duty
        @(posedge clk);
        #1;
        do_write(4'd0, 8'd255);
        do_write(4'd5, 8'd128);
        wait_commit();
        measure();
`ifdef LED_PWM_FADE_EN
        chk("fade_ch0_first", 32'(hi_cnt[0]), 2);
        chk("fade_ch5_first", 32'(hi_cnt[5]), 2);
`else
        chk("duty_ch0", 32'(hi_cnt[0]), 510);
        chk("duty_ch5", 32'(hi_cnt[5]), 256);
`endif
        chk("duty_ch1", 32'(hi_cnt[1]), 0);

        // Write attempted in the commit cycle
        wait_commit();
        wr_en = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'd77;
        chk("commit_ready_low", 32'(wr_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_commit_ready", 32'(wr_ready), 1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wait_commit();
        measure();
`ifndef LED_PWM_FADE_EN
        chk("duty_ch3", 32'(hi_cnt[3]), 154);
`endif

        // Out-of-range addresses
        @(posedge clk);
        #1;
        do_write(4'd11, 8'd200);
        do_write(4'd15, 8'd50);
        wait_commit();
        measure();
`ifndef LED_PWM_FADE_EN
        chk("oor_ch0", 32'(hi_cnt[0]), 510);
        chk("oor_ch5", 32'(hi_cnt[5]), 256);
        chk("oor_ch3", 32'(hi_cnt[3]), 154);
`endif
        chk("oor_ch10", 32'(hi_cnt[10]), 0);

        // Mid-frame reset
        repeat (100) @(posedge clk);
        #1;
`ifndef LED_PWM_FADE_EN
        chk("pre_rst_lit", 32'(ledc[0]), 1);
`endif
        rst = 1'b1;
        #1;
        chk("rst_async_dark", 32'(ledc), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        nz = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (ledc != '0) nz++;
        end
        chk("post_rst_dark", 32'(nz), 0);

        // Write coincident with reset release, then fade/step behaviour
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'd3;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wait_commit();
        for (int f = 0; f < 4; f++) begin
            measure();
`ifdef LED_PWM_FADE_EN
            chk("fade_up", 32'(hi_cnt[2]), 32'(2 * ((f < 2) ? f + 1 : 3)));
`else
            chk("step_up", 32'(hi_cnt[2]), 6);
`endif
        end
        do_write(4'd2, 8'd0);
        wait_commit();
        for (int f = 0; f < 4; f++) begin
            measure();
`ifdef LED_PWM_FADE_EN
            chk("fade_down", 32'(hi_cnt[2]), 32'(2 * ((f < 2) ? 2 - f : 0)));
`else
            chk("step_down", 32'(hi_cnt[2]), 0);
`endif
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 Parameter NUM_LEDS, default 11, number of PWM channels driving the ledc outputs.
REQ-002 Parameter PWM_BITS, default 8, duty-cycle resolution.
REQ-003 Parameter PRESCALE, default 125, clk cycles per PWM step (8 MHz clk -> ~251 Hz frame).
REQ-004 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  upstream pattern stage requests a brightness write.
REQ-007 wr_addr  input  4  channel index to write.
REQ-008 wr_data  input  PWM_BITS  target duty for that channel.
REQ-009 wr_ready  output  1  high when a write is accepted this cycle.
REQ-010 frame_start  output  1  one-cycle pulse at each PWM frame boundary; the upstream sequencer uses it as its step tick.
REQ-011 ledc  output  NUM_LEDS  registered LED drive, 1 = lit.

Function
REQ-012 Prescaler counts 0..PRESCALE-1 and wraps; step tick asserted in the cycle the count equals PRESCALE-1.
REQ-013 PWM counter, PWM_BITS wide, advances on each step tick over 0..2^PWM_BITS-2 and wraps to 0 (period 2^PWM_BITS-1 steps).
REQ-014 Frame boundary is the step tick on which the PWM counter wraps to 0; frame_start is high for exactly the following cycle.
REQ-015 Write handshake: a write is accepted when wr_en and wr_ready are both high in the same cycle; wr_data is stored in shadow[wr_addr] at that edge.
REQ-016 wr_ready is high in every cycle except the commit cycle (the cycle frame_start is high); wr_en in that cycle is ignored, and the producer holds it.
REQ-017 Writes with wr_addr >= NUM_LEDS are accepted (handshake completes) and discarded.
REQ-018 In the commit cycle, active duty is updated from shadow for all channels simultaneously; writes never reach active duty mid-frame.
REQ-019 ledc[i] = 1 when PWM counter < active[i], registered one cycle after the counter.
REQ-020 active[i] = 0 gives ledc[i] constantly 0; active[i] = 2^PWM_BITS-1 gives constantly 1; no single-step glitch at wrap.
REQ-021 Latency: write accepted in cycle N -> ledc reflects the value from the first frame whose commit cycle is later than N, with output change one cycle after the commit cycle.
REQ-022 Multiple writes to one channel within a frame: the last accepted write wins.

Reset
REQ-023 On rst: prescaler, PWM counter, all shadow and active duty registers = 0; ledc = 0; frame_start = 0; wr_ready = 1.
REQ-024 Reset asserted mid-frame takes effect immediately; after release the first frame_start occurs PRESCALE*(2^PWM_BITS-1) cycles later.
REQ-025 A write coincident with reset release is accepted.

Configuration
REQ-026 Macro LED_PWM_FADE_EN: when defined, each commit moves active[i] one count toward shadow[i] (+1, -1, or hold if equal), giving linear fades; when undefined, each commit copies shadow[i] into active[i] directly.
REQ-027 With LED_PWM_FADE_EN, active never overshoots or wraps past its target; interface, timing and reset unchanged.

Verification (bench uses PRESCALE=2, PWM_BITS=8, NUM_LEDS=11)
REQ-028 Reset then idle 2000 cycles -> ledc = 0 throughout; frame_start pulses every 510 cycles.
REQ-029 Write addr 0 = 255, addr 5 = 128 -> after next commit ledc[0] constant 1, ledc[5] high 256 of 510 cycles per frame, others 0.
REQ-030 Assert wr_en on the commit cycle -> wr_ready = 0, no write accepted, accepted on the next cycle.
REQ-031 Write addr 11 = 200 and addr 15 = 50 -> handshake completes, no ledc bit changes.
REQ-032 Assert rst mid-frame with channels lit -> ledc = 0 immediately; after release, all outputs stay 0 until written.
REQ-033 With LED_PWM_FADE_EN: write addr 2 = 3 -> active[2] reaches 1, 2, 3 on three successive commits, then holds; write 0 -> decrements 3, 2, 1, 0.
